// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and helpers used by the datapath building blocks.
package mips_pkg;

    localparam int unsigned DATA_W = 32;

    // Output-stage states; the state bit is the output-valid flag itself.
    localparam logic StEmpty = 1'b0;
    localparam logic StFull  = 1'b1;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority (mode=0) or round-robin from ptr (mode=1).
module rr_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned SELW = clog2_min1(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    input  logic            mode,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    logic [2*NCH-1:0] req_dbl;
    logic [NCH-1:0]   req_rot;
    int unsigned      base;
    int unsigned      idx;

    always_comb begin
        base    = (mode && (32'(ptr) < NCH)) ? 32'(ptr) : 32'd0;
        req_dbl = {req, req};
        // Rotating the doubled vector puts the start position at bit 0.
        req_rot = req_dbl[base +: NCH];
        any     = |req_rot;
        idx     = base;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                idx = base + 32'(i);
            end
        end
        if (idx >= NCH) begin
            idx = idx - NCH;
        end
        gnt_idx = idx[SELW-1:0];
        gnt     = any ? (NCH'(1) << idx) : '0;
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrating mux with a single registered output stage and back-pressure.
module arb_mux
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned NCH   = 4,
    parameter int unsigned MODE  = 1,
    parameter int unsigned SELW  = clog2_min1(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic [NCH-1:0]   gnt;
    logic [SELW-1:0]  gnt_idx;
    logic             gnt_any;
    logic [WIDTH-1:0] gnt_data;
    logic             can_load;
    logic             accept;
    logic             state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .mode    (MODE != 0),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    // One-hot AND-OR select keeps in_data off every control path.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            gnt_data |= in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}};
        end
    end

    always_comb begin
        can_load = (state_q == StEmpty) || out_ready;
        accept   = gnt_any && can_load;
        in_ready = can_load ? gnt : '0;
        state_d  = state_q;
        data_d   = data_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        if (accept) begin
            state_d = StFull;
            data_d  = gnt_data;
            sel_d   = gnt_idx;
            if (MODE != 0 && NCH > 1) begin
                ptr_d = (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + SELW'(1);
            end
        end else if (state_q == StFull && out_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench: round-robin and fixed-priority 4-channel instances plus a 3-channel one.
module tb_arb_mux;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic           out_ready;

    logic [3:0]     ir_rr, ir_fp;
    logic [2:0]     ir_3;
    logic           ov_rr, ov_fp, ov_3;
    logic [W-1:0]   od_rr, od_fp, od_3;
    logic [1:0]     os_rr, os_fp, os_3;

    int n_checks = 0;
    int n_errors = 0;

    // Entries are {sel[1:0], data[31:0]}.
    logic [33:0]  sb0[$];
    logic [33:0]  sb1[$];
    logic [33:0]  sb2[$];
    int           mptr[3];
    logic [W-1:0] last_data[3];
    logic [1:0]   last_sel[3];

    logic [4*W-1:0] d;

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(W), .NCH(4), .MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir_rr),
        .out_valid(ov_rr), .out_data(od_rr), .out_sel(os_rr), .out_ready(out_ready)
    );

    arb_mux #(.WIDTH(W), .NCH(4), .MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir_fp),
        .out_valid(ov_fp), .out_data(od_fp), .out_sel(os_fp), .out_ready(out_ready)
    );

    arb_mux #(.WIDTH(W), .NCH(3), .MODE(1)) dut_3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2:0]), .in_data(in_data[3*W-1:0]),
        .in_ready(ir_3), .out_valid(ov_3), .out_data(od_3), .out_sel(os_3),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant(input logic [3:0] v, input int n, input int start);
        for (int k = 0; k < n; k++) begin
            if (v[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    task automatic lane_eval(input int lane);
        int          n;
        int          g;
        logic        rr;
        logic        ov;
        logic [W-1:0] od;
        logic [1:0]  os;
        logic [3:0]  ir;
        logic [3:0]  exp_ir;
        logic        can_load;
        logic [33:0] q[$];
        string       t;
        case (lane)
            0: begin n = 4; rr = 1'b1; ov = ov_rr; od = od_rr; os = os_rr; ir = ir_rr; q = sb0; end
            1: begin n = 4; rr = 1'b0; ov = ov_fp; od = od_fp; os = os_fp; ir = ir_fp; q = sb1; end
            default: begin
                n = 3; rr = 1'b1; ov = ov_3; od = od_3; os = os_3; ir = {1'b0, ir_3}; q = sb2;
            end
        endcase
        t = $sformatf("lane%0d", lane);
        check({t, " out_valid"}, 64'(ov), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check({t, " out_data"}, 64'(od), 64'(q[0][31:0]));
            check({t, " out_sel"}, 64'(os), 64'(q[0][33:32]));
        end else begin
            check({t, " held_data"}, 64'(od), 64'(last_data[lane]));
            check({t, " held_sel"}, 64'(os), 64'(last_sel[lane]));
        end
        can_load = (q.size() == 0) || out_ready;
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        g = model_grant(in_valid, n, rr ? mptr[lane] : 0);
        exp_ir = (g >= 0 && can_load) ? (4'b1 << g) : 4'b0;
        check({t, " in_ready"}, 64'(ir), 64'(exp_ir));
        if (g >= 0 && can_load) begin
            q.push_back({2'(g), in_data[g*W +: W]});
            last_data[lane] = in_data[g*W +: W];
            last_sel[lane]  = 2'(g);
            if (rr) mptr[lane] = (g == n - 1) ? 0 : g + 1;
        end
        if (lane == 2) check({t, " sel_range"}, 64'(os == 2'd3), 64'd0);
        case (lane)
            0:       sb0 = q;
            1:       sb1 = q;
            default: sb2 = q;
        endcase
    endtask

    task automatic step(input logic [3:0] v, input logic ordy, input logic [4*W-1:0] data);
        @(posedge clk);
        #1;
        in_valid  = v;
        out_ready = ordy;
        in_data   = data;
        @(negedge clk);
        for (int l = 0; l < 3; l++) lane_eval(l);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, " rr out_valid"}, 64'(ov_rr), 64'd0);
        check({tag, " rr out_data"}, 64'(od_rr), 64'd0);
        check({tag, " rr out_sel"}, 64'(os_rr), 64'd0);
        check({tag, " rr in_ready"}, 64'(ir_rr), 64'd0);
        check({tag, " fp out_valid"}, 64'(ov_fp), 64'd0);
        check({tag, " fp out_data"}, 64'(od_fp), 64'd0);
        check({tag, " n3 out_valid"}, 64'(ov_3), 64'd0);
        check({tag, " n3 out_data"}, 64'(od_3), 64'd0);
        check({tag, " n3 in_ready"}, 64'(ir_3), 64'd0);
        sb0.delete();
        sb1.delete();
        sb2.delete();
        for (int l = 0; l < 3; l++) begin
            mptr[l]      = 0;
            last_data[l] = '0;
            last_sel[l]  = '0;
        end
    endtask

    initial begin
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        d         = '0;
        #1 rst = 1'b1;
        #1 reset_checks("reset");
        @(negedge clk);
        rst = 1'b0;
        step(4'b0000, 1'b1, d);
        step(4'b0000, 1'b1, d);

        // Single requester on channel 2.
        d[2*W +: W] = 32'h0000FFFF;
        step(4'b0100, 1'b1, d);
        step(4'b0000, 1'b1, d);

        // All requesting: round-robin rotation on lane 0, channel 0 always on lane 1.
        for (int i = 0; i < 4; i++) d[i*W +: W] = 32'hA0 + i;
        repeat (9) step(4'b1111, 1'b1, d);

        // Fixed priority with channels 1 and 3 requesting.
        repeat (4) step(4'b1010, 1'b1, d);

        // Back-pressure, then simultaneous drain and accept.
        d[0 +: W] = 32'h12345678;
        step(4'b0001, 1'b1, d);
        repeat (3) step(4'b1111, 1'b0, d);
        d[0 +: W] = 32'hCAFE0001;
        step(4'b0001, 1'b1, d);
        step(4'b1111, 1'b1, d);
        step(4'b0000, 1'b1, d);
        step(4'b0000, 1'b1, d);

        // 3-channel wrap: grant 1 sets ptr to 2, then 0 and 1 win in turn.
        step(4'b0010, 1'b1, d);
        step(4'b0011, 1'b1, d);
        step(4'b0011, 1'b1, d);
        step(4'b0000, 1'b1, d);

        // Random traffic with random back-pressure.
        repeat (60) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            step(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, d);
        end

        // Asynchronous reset while a beat is held.
        d = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        step(4'b1110, 1'b1, d);
        step(4'b1110, 1'b0, d);
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = '0;
        #1 reset_checks("midbeat");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            step(4'($urandom_range(0, 15)), $urandom_range(0, 1) != 0, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised N-channel, WIDTH-bit arbitrating multiplexer; successor to the plain 2:1 32-bit datapath mux.
- Selects one of NCH valid/ready source channels per cycle and registers the winning word plus its channel index into a single output stage.
- Used in the MIPS datapath where several producers share one consumer, e.g. writeback sources or memory request ports.
- Provides fixed-priority or round-robin arbitration, back-pressure, and one-cycle latency.

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- NCH, 4, number of input channels, 1..16; need not be a power of two.
- MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- SELW, $clog2(NCH) with a minimum of 1, width of the channel-index fields (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  NCH  per-channel request; bit i belongs to channel i.
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  NCH  one-hot or zero; channel i's word is accepted this cycle when in_valid[i] && in_ready[i].
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered winning word.
- out_sel  out  SELW  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
  - in_ready is combinational and therefore 0 while out_valid=0 and no in_valid is asserted.
  - Reset mid-operation discards any held beat; no partial transfer survives.
- Output stage has two states, encoded by out_valid: EMPTY (0) and FULL (1).
- can_load = !out_valid || out_ready.
- Grant, combinational, computed from in_valid only:
  - MODE=0: lowest index i with in_valid[i]=1.
  - MODE=1: first i with in_valid[i]=1, searching ptr, ptr+1, … NCH-1, 0, … ptr-1.
  - No valid input means no grant.
- in_ready[g] = can_load for the granted channel g; all other bits are 0.
  - in_ready must not depend on in_data.
  - in_ready may depend on in_valid, through the grant.
- Accept (grant exists && can_load), next edge:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - MODE=1 only: ptr <= (g==NCH-1) ? 0 : g+1. Wrap is explicit; no power-of-two modulo.
- Drain without accept (out_valid && out_ready, no grant): out_valid <= 0; out_data and out_sel hold their last values.
- Stall (out_valid && !out_ready):
  - out_data, out_sel and out_valid hold.
  - All in_ready bits are 0.
  - ptr holds.
- Simultaneous drain and accept: the new beat replaces the old one in the same edge. Throughput is 1 beat/cycle, latency is 1 cycle from accept to out_valid.
- ptr changes only on accept. Losing requesters keep in_valid asserted; the block never drops or duplicates a beat.
- NCH=1: grant = in_valid[0]; out_sel stays 0; ptr is unused and constant 0.
- No combinational path from in_data to out_data; the only comb paths are in_valid/out_ready -> in_ready.

Decomposition:
- Shared package mips_pkg:
  - constant DATA_W = 32, used as the WIDTH default.
  - function clog2_min1(n) for SELW.
- One natural sub-module: rr_arbiter.
  - Inputs: req[NCH], ptr[SELW], mode.
  - Outputs: gnt one-hot [NCH], gnt_idx[SELW], any.
  - Purely combinational, using double-width request rotation.
- arb_mux instantiates rr_arbiter and holds the ptr and output registers.

Test Plan:
All cases use WIDTH=32, NCH=4 unless stated.
- Reset: assert rst mid-beat with out_valid=1 -> out_valid, out_data and out_sel read 0 immediately (async), before any clock edge; in_ready=0000 with no requests.
- Single channel, MODE=1: in_valid=0100, in_data[2]=32'h0000FFFF, out_ready=1 -> in_ready=0100; one cycle later out_valid=1, out_data=32'h0000FFFF, out_sel=2; ptr becomes 3.
- Round-robin fairness: in_valid=1111 held, out_ready=1, data_i=32'hA0+i -> out_sel sequence 0,1,2,3,0,… one beat per cycle; out_data 32'hA0,32'hA1,32'hA2,32'hA3.
- Fixed priority, MODE=0: in_valid=1010 held -> out_sel always 1; channel 3 in_ready never asserted.
- Back-pressure: FULL with out_data=32'h12345678, out_ready=0 for 3 cycles -> out_data and out_sel stable, in_ready=0000, ptr unchanged; on out_ready=1 with in_valid=0001 -> simultaneous drain and accept, out_data becomes in_data[0] next cycle with no bubble.
- Wrap and non-power-of-two: NCH=3, MODE=1, ptr=2, in_valid=011 -> grant 0, then 1; ptr goes 2 -> 1 -> 2 (wraps through index 2 -> 0); SELW=2 and out_sel never reads 3.
